// File: rtl/ctrl_delay_pipe_pkg.sv
// Shared width and latency defaults for the control-alignment pipeline.
// Holds plain constants and a sizing helper only; no types cross the ports.
package ctrl_delay_pipe_pkg;

  localparam int ADDR_WIDTH_DEF    = 5;
  localparam int ALUMODE_WIDTH_DEF = 4;
  localparam int OPMODE_WIDTH_DEF  = 7;
  localparam int INMODE_WIDTH_DEF  = 5;

  localparam int WEB_DLY_DEF = 3;
  localparam int OPM_DLY_DEF = 2;
  localparam int INM_DLY_DEF = 1;

  // Bits needed to count 0..depth valid entries.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One enable/flush-aware stage of the control pipeline.
// Write enable is re-gated with valid; flush clears only valid/web.
module ctrl_pipe_stage
  import ctrl_delay_pipe_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int ALUMODE_WIDTH = ALUMODE_WIDTH_DEF,
  parameter int OPMODE_WIDTH  = OPMODE_WIDTH_DEF,
  parameter int INMODE_WIDTH  = INMODE_WIDTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     flush_i,
  input  logic                     prev_valid,
  input  logic                     prev_web,
  input  logic [ADDR_WIDTH-1:0]    prev_addr,
  input  logic [ALUMODE_WIDTH-1:0] prev_alumode,
  input  logic [OPMODE_WIDTH-1:0]  prev_opmode,
  input  logic [INMODE_WIDTH-1:0]  prev_inmode,
  output logic                     valid,
  output logic                     web,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic [ALUMODE_WIDTH-1:0] alumode,
  output logic [OPMODE_WIDTH-1:0]  opmode,
  output logic [INMODE_WIDTH-1:0]  inmode
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid   <= 1'b0;
      web     <= 1'b0;
      addr    <= '0;
      alumode <= '0;
      opmode  <= '0;
      inmode  <= '0;
    end else if (flush_i) begin
      // Mode and address fields keep their value; only the qualifiers drop.
      valid <= 1'b0;
      web   <= 1'b0;
    end else if (en_i) begin
      valid   <= prev_valid;
      web     <= prev_web & prev_valid;
      addr    <= prev_addr;
      alumode <= prev_alumode;
      opmode  <= prev_opmode;
      inmode  <= prev_inmode;
    end
  end

endmodule

// File: rtl/ctrl_delay_pipe.sv
// Aligns BRAM1 write and DSP mode fields to their consuming cycles by per-field latency.
// Tracks valid entries for drain detection; en_i stalls all stages, flush_i clears valids.
module ctrl_delay_pipe
  import ctrl_delay_pipe_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int ALUMODE_WIDTH = ALUMODE_WIDTH_DEF,
  parameter int OPMODE_WIDTH  = OPMODE_WIDTH_DEF,
  parameter int INMODE_WIDTH  = INMODE_WIDTH_DEF,
  parameter int WEB_DLY       = WEB_DLY_DEF,
  parameter int OPM_DLY       = OPM_DLY_DEF,
  parameter int INM_DLY       = INM_DLY_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic                           flush_i,
  input  logic                           valid_i,
  input  logic                           bram1_web_i,
  input  logic [ADDR_WIDTH-1:0]          bram1_w_addr_i,
  input  logic [ALUMODE_WIDTH-1:0]       alumode_i,
  input  logic [OPMODE_WIDTH-1:0]        opmode_i,
  input  logic [INMODE_WIDTH-1:0]        inmode_i,
  output logic                           valid_o,
  output logic                           bram1_web_o,
  output logic [ADDR_WIDTH-1:0]          bram1_w_addr_o,
  output logic [ALUMODE_WIDTH-1:0]       alumode_o,
  output logic [OPMODE_WIDTH-1:0]        opmode_o,
  output logic [INMODE_WIDTH-1:0]        inmode_o,
  output logic [$clog2(WEB_DLY+1)-1:0]   inflight_o,
  output logic                           idle_o,
  output logic                           flushed_o
);

  localparam int CNT_W = cnt_width(WEB_DLY);

  // Index 0 is the raw input; index k is the register of stage k.
  logic                     stg_valid   [0:WEB_DLY];
  logic                     stg_web     [0:WEB_DLY];
  logic [ADDR_WIDTH-1:0]    stg_addr    [0:WEB_DLY];
  logic [ALUMODE_WIDTH-1:0] stg_alumode [0:WEB_DLY];
  logic [OPMODE_WIDTH-1:0]  stg_opmode  [0:WEB_DLY];
  logic [INMODE_WIDTH-1:0]  stg_inmode  [0:WEB_DLY];

  assign stg_valid[0]   = valid_i;
  assign stg_web[0]     = bram1_web_i;
  assign stg_addr[0]    = bram1_w_addr_i;
  assign stg_alumode[0] = alumode_i;
  assign stg_opmode[0]  = opmode_i;
  assign stg_inmode[0]  = inmode_i;

  // Fields past their tap stage feed nothing and are trimmed by synthesis.
  for (genvar k = 1; k <= WEB_DLY; k++) begin : g_stage
    ctrl_pipe_stage #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .ALUMODE_WIDTH (ALUMODE_WIDTH),
      .OPMODE_WIDTH  (OPMODE_WIDTH),
      .INMODE_WIDTH  (INMODE_WIDTH)
    ) u_stage (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .en_i         (en_i),
      .flush_i      (flush_i),
      .prev_valid   (stg_valid[k-1]),
      .prev_web     (stg_web[k-1]),
      .prev_addr    (stg_addr[k-1]),
      .prev_alumode (stg_alumode[k-1]),
      .prev_opmode  (stg_opmode[k-1]),
      .prev_inmode  (stg_inmode[k-1]),
      .valid        (stg_valid[k]),
      .web          (stg_web[k]),
      .addr         (stg_addr[k]),
      .alumode      (stg_alumode[k]),
      .opmode       (stg_opmode[k]),
      .inmode       (stg_inmode[k])
    );
  end

  assign valid_o        = stg_valid[WEB_DLY];
  assign bram1_web_o    = stg_web[WEB_DLY];
  assign bram1_w_addr_o = stg_addr[WEB_DLY];
  assign alumode_o      = stg_alumode[OPM_DLY];
  assign opmode_o       = stg_opmode[OPM_DLY];
  assign inmode_o       = stg_inmode[INM_DLY];

  logic exit_valid;
  assign exit_valid = stg_valid[WEB_DLY];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_o <= '0;
      flushed_o  <= 1'b0;
    end else begin
      flushed_o <= flush_i && ((inflight_o != '0) || valid_i);
      if (flush_i) begin
        inflight_o <= '0;
      end else if (en_i) begin
        case ({valid_i, exit_valid})
          2'b10:   inflight_o <= inflight_o + CNT_W'(1);
          2'b01:   inflight_o <= inflight_o - CNT_W'(1);
          default: inflight_o <= inflight_o;
        endcase
      end
    end
  end

  assign idle_o = (inflight_o == '0);

endmodule
